// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux_scan channel selector.
package mux_scan_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  localparam int DWELL_DEFAULT = 4;

  function automatic int sel_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_timer.sv
// Scan pointer and dwell counter; pulses wrap when the pointer rolls from CH-1 to 0.
module mux_scan_timer
  import mux_scan_pkg::*;
#(
  parameter int CH    = 4,
  parameter int DWELL = DWELL_DEFAULT,
  localparam int SELW = sel_width(CH),
  localparam int DW   = $clog2(DWELL + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            hold,
  input  logic            load,
  input  logic [SELW-1:0] load_val,
  output logic [SELW-1:0] ptr,
  output logic            wrap
);

  localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
  localparam logic [SELW-1:0] PTR_LAST   = SELW'(CH - 1);

  logic [DW-1:0] dwell_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      dwell_cnt <= '0;
      wrap      <= 1'b0;
    end else if (load) begin
      ptr       <= load_val;
      dwell_cnt <= '0;
      wrap      <= 1'b0;
    end else if (run && !hold) begin
      if (dwell_cnt == DWELL_LAST) begin
        dwell_cnt <= '0;
        ptr       <= (ptr == PTR_LAST) ? '0 : ptr + SELW'(1);
        wrap      <= (ptr == PTR_LAST);
      end else begin
        dwell_cnt <= dwell_cnt + DW'(1);
        wrap      <= 1'b0;
      end
    end else begin
      // Leaving scan clears the dwell count but keeps the pointer.
      if (!run) dwell_cnt <= '0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_scan.sv
// N-channel selector with manual and scanning modes and registered output.
// Define MUX_SCAN_ONEHOT_EN to add the one-hot digit-enable output dout_oh.
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter int CH    = 4,
  parameter int W     = 2,
  parameter int DWELL = DWELL_DEFAULT,
  localparam int SELW = sel_width(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic            hold,
  input  logic [CH*W-1:0] din,
  output logic [W-1:0]    dout,
  output logic [SELW-1:0] dout_ch,
  output logic            dout_vld,
  output logic            wrap
`ifdef MUX_SCAN_ONEHOT_EN
  ,
  output logic [CH-1:0]   dout_oh
`endif
);

  mode_e           state;
  mode_e           mode_in;
  logic [W-1:0]    ch_data [CH];
  logic            sel_ok;
  logic            scan_path;
  logic            load;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] next_ch;
  logic            next_ok;
  logic [W-1:0]    next_data;

  assign mode_in = mode_e'(mode);

  always_comb begin
    for (int k = 0; k < CH; k++) ch_data[k] = din[k*W +: W];
  end

  // A request for manual mode takes over the output on the same edge.
  assign sel_ok    = (int'(sel) < CH);
  assign scan_path = (state == MODE_SCAN) && (mode_in == MODE_SCAN);
  assign load      = (state == MODE_MANUAL) && (mode_in == MODE_SCAN);
  assign next_ch   = scan_path ? ptr : sel;
  assign next_ok   = scan_path ? 1'b1 : sel_ok;
  assign next_data = next_ok ? ch_data[next_ch] : '0;

  mux_scan_timer #(
    .CH    (CH),
    .DWELL (DWELL)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (scan_path),
    .hold     (hold),
    .load     (load),
    .load_val (sel_ok ? sel : '0),
    .ptr      (ptr),
    .wrap     (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MODE_MANUAL;
      dout     <= '0;
      dout_ch  <= '0;
      dout_vld <= 1'b0;
    end else begin
      state    <= mode_in;
      dout     <= next_data;
      dout_ch  <= next_ch;
      dout_vld <= (mode_in == state);
    end
  end

`ifdef MUX_SCAN_ONEHOT_EN
  always_ff @(posedge clk) begin
    if (rst) dout_oh <= '0;
    else     dout_oh <= next_ok ? (CH'(1) << next_ch) : '0;
  end
`endif

endmodule
